// File: rtl/vram_pkg.sv
// Shared types and default sizes for the frame-memory port arbiter.
// A read tag records the owner of an issued access and whether its address was out of range.
package vram_pkg;

   localparam int DEF_ADDR_W      = 14;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_FRAME_WORDS = 10000;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   oob;
   } rd_tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the RAM access latency.
// An asynchronous clear drops every in-flight tag.
module vram_rd_tag_pipe
   import vram_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t stage_q [DEPTH];
   rd_tag_t stage_d [DEPTH];

   always_comb begin
      stage_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares one frame-memory port between the VGA scan-out reader and a CPU/DMA requester.
// VGA has priority; a starvation counter forces a CPU grant after MAX_STARVE back-to-back VGA wins.
module vram_port_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int FRAME_WORDS = DEF_FRAME_WORDS,
   parameter int RD_LAT      = 1,
   parameter int MAX_STARVE  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   localparam int SW = $clog2(MAX_STARVE + 1);
   localparam logic [ADDR_W:0] FRAME_LIM = (ADDR_W+1)'(FRAME_WORDS);

   function automatic logic is_oob(input logic [ADDR_W-1:0] a);
      return {1'b0, a} >= FRAME_LIM;
   endfunction

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_wren_q, mem_wren_d;
   logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
   logic              cpu_err_q, cpu_err_d;
   logic              vga_rvalid_q, vga_rvalid_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

   logic    starved;
   logic    vga_gnt_c, cpu_gnt_c;
   logic    sel_oob;
   rd_tag_t tag_in, tag_out;

   // Grants are combinational; both are held low while reset is asserted.
   always_comb begin
      starved   = (starve_cnt_q == SW'(MAX_STARVE));
      cpu_gnt_c = rst && cpu_req && (!vga_req || starved);
      vga_gnt_c = rst && vga_req && !cpu_gnt_c;
      sel_oob   = is_oob(cpu_gnt_c ? cpu_addr : vga_addr);
   end

   always_comb begin
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_wren_d   = 1'b0;
      cpu_err_d    = 1'b0;
      starve_cnt_d = starve_cnt_q;
      tag_in       = '0;

      if (vga_gnt_c) begin
         mem_addr_d   = vga_addr;
         tag_in.valid = 1'b1;
         tag_in.owner = OWN_VGA;
         tag_in.oob   = sel_oob;
      end else if (cpu_gnt_c) begin
         mem_addr_d   = cpu_addr;
         mem_data_d   = cpu_wdata;
         mem_wren_d   = cpu_we && !sel_oob;
         cpu_err_d    = sel_oob;
         tag_in.valid = !cpu_we;
         tag_in.owner = OWN_CPU;
         tag_in.oob   = sel_oob;
      end

      if (!cpu_req || cpu_gnt_c) begin
         starve_cnt_d = '0;
      end else if (vga_gnt_c && !starved) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   // Read return: the tag leaving the pipe lines up with mem_q for that access.
   always_comb begin
      vga_rvalid_d = 1'b0;
      cpu_rvalid_d = 1'b0;
      vga_rdata_d  = vga_rdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      if (tag_out.valid && tag_out.owner == OWN_VGA) begin
         vga_rvalid_d = 1'b1;
         vga_rdata_d  = tag_out.oob ? '0 : mem_q;
      end else if (tag_out.valid && tag_out.owner == OWN_CPU) begin
         cpu_rvalid_d = 1'b1;
         cpu_rdata_d  = tag_out.oob ? '0 : mem_q;
      end
   end

   vram_rd_tag_pipe #(
      .DEPTH (RD_LAT + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_wren_q   <= 1'b0;
         starve_cnt_q <= '0;
         cpu_err_q    <= 1'b0;
         vga_rvalid_q <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         vga_rdata_q  <= '0;
         cpu_rdata_q  <= '0;
      end else begin
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_wren_q   <= mem_wren_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_err_q    <= cpu_err_d;
         vga_rvalid_q <= vga_rvalid_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         vga_rdata_q  <= vga_rdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
      end
   end

   assign vga_gnt    = vga_gnt_c;
   assign cpu_gnt    = cpu_gnt_c;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign mem_wren   = mem_wren_q;
   assign cpu_err    = cpu_err_q;
   assign vga_rvalid = vga_rvalid_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign vga_rdata  = vga_rdata_q;
   assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a one-cycle-latency RAM model on the memory port.
// Unwritten RAM words read back as 0xA0000000 | addr, except address 5 which holds 0xDEADBEEF.
module tb_vram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vga_req;
   logic [13:0] vga_addr;
   logic        vga_gnt;
   logic        vga_rvalid;
   logic [31:0] vga_rdata;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic [13:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q = '0;

   int errors = 0;
   int checks = 0;

   logic [31:0] ram      [16384];
   bit          written  [16384];

   always #5 clk = ~clk;

   vram_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .vga_gnt    (vga_gnt),
      .vga_rvalid (vga_rvalid),
      .vga_rdata  (vga_rdata),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_wren   (mem_wren),
      .mem_q      (mem_q)
   );

   function automatic logic [31:0] init_val(input logic [13:0] a);
      if (a == 14'd5) return 32'hDEADBEEF;
      return 32'hA0000000 | {18'd0, a};
   endfunction

   always @(posedge clk) begin
      if (mem_wren) begin
         ram[mem_addr]     <= mem_data;
         written[mem_addr] <= 1'b1;
      end
      mem_q <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic exp_v;
      rst = 1'b0; vga_req = 1'b1; vga_addr = 14'd3;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'd4; cpu_wdata = '0;

      // Reset held with both requesters asking
      repeat (2) @(posedge clk);
      #1; settle();
      check("rst_vga_gnt", vga_gnt, 0);
      check("rst_cpu_gnt", cpu_gnt, 0);
      check("rst_mem_wren", mem_wren, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_vga_rvalid", vga_rvalid, 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_cpu_err", cpu_err, 0);
      rst = 1'b1; settle();
      check("rel_vga_gnt", vga_gnt, 1);
      check("rel_cpu_gnt", cpu_gnt, 0);
      next(); vga_req = 1'b0; cpu_req = 1'b0; settle();
      check("rel_mem_addr", mem_addr, 14'd3);
      next(); next(); settle();
      check("rel_vga_rvalid", vga_rvalid, 1);
      check("rel_vga_rdata", vga_rdata, 32'hA0000003);
      next(); settle();
      check("rel_vga_pulse", vga_rvalid, 0);

      // VGA-only read of address 5
      vga_req = 1'b1; vga_addr = 14'd5; settle();
      check("t2_vga_gnt", vga_gnt, 1);
      next(); vga_req = 1'b0; settle();
      check("t2_mem_addr", mem_addr, 14'd5);
      check("t2_mem_wren", mem_wren, 0);
      next(); settle();
      check("t2_early_rvalid", vga_rvalid, 0);
      next(); settle();
      check("t2_vga_rvalid", vga_rvalid, 1);
      check("t2_vga_rdata", vga_rdata, 32'hDEADBEEF);
      check("t2_cpu_rvalid", cpu_rvalid, 0);

      // CPU write then read-back of address 100
      next();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'd100; cpu_wdata = 32'h12345678; settle();
      check("t3_wr_cpu_gnt", cpu_gnt, 1);
      check("t3_wr_vga_gnt", vga_gnt, 0);
      next(); cpu_we = 1'b0; cpu_wdata = 32'h0; settle();
      check("t3_mem_wren", mem_wren, 1);
      check("t3_mem_addr", mem_addr, 14'd100);
      check("t3_mem_data", mem_data, 32'h12345678);
      check("t3_rd_cpu_gnt", cpu_gnt, 1);
      next(); cpu_req = 1'b0; settle();
      check("t3_wren_once", mem_wren, 0);
      next(); settle();
      check("t3_wr_no_rvalid", cpu_rvalid, 0);
      next(); settle();
      check("t3_rd_rvalid", cpu_rvalid, 1);
      check("t3_rd_rdata", cpu_rdata, 32'h12345678);

      // Both requesting for 30 cycles: 8 VGA grants then 1 CPU grant, repeating
      next();
      vga_req = 1'b1; vga_addr = 14'd7; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'd20;
      for (int k = 0; k < 30; k++) begin
         settle();
         check($sformatf("t4_vga_gnt_%0d", k), vga_gnt, (k % 9) != 8);
         check($sformatf("t4_cpu_gnt_%0d", k), cpu_gnt, (k % 9) == 8);
         if (k >= 3) begin
            exp_v = ((k - 3) % 9) != 8;
            check($sformatf("t4_vga_rv_%0d", k), vga_rvalid, exp_v);
            check($sformatf("t4_cpu_rv_%0d", k), cpu_rvalid, !exp_v);
            if (exp_v) check($sformatf("t4_vga_rd_%0d", k), vga_rdata, 32'hA0000007);
            else       check($sformatf("t4_cpu_rd_%0d", k), cpu_rdata, 32'hA0000014);
         end
         next();
      end
      vga_req = 1'b0; cpu_req = 1'b0;
      repeat (4) next();

      // Out-of-range CPU read and write
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'd10000; settle();
      check("t5_rd_gnt", cpu_gnt, 1);
      next(); cpu_we = 1'b1; cpu_addr = 14'd16383; cpu_wdata = 32'hFFFFFFFF; settle();
      check("t5_rd_err", cpu_err, 1);
      check("t5_wr_gnt", cpu_gnt, 1);
      next(); cpu_req = 1'b0; cpu_we = 1'b0; settle();
      check("t5_wr_err", cpu_err, 1);
      check("t5_wr_wren", mem_wren, 0);
      next(); settle();
      check("t5_rd_rvalid", cpu_rvalid, 1);
      check("t5_rd_zero", cpu_rdata, 32'h0);
      check("t5_err_pulse", cpu_err, 0);
      next(); settle();
      check("t5_wr_no_rvalid", cpu_rvalid, 0);

      // Out-of-range VGA read: zero data, no error
      vga_req = 1'b1; vga_addr = 14'd12000; settle();
      check("t5v_gnt", vga_gnt, 1);
      next(); vga_req = 1'b0; settle();
      check("t5v_no_err", cpu_err, 0);
      next(); next(); settle();
      check("t5v_rvalid", vga_rvalid, 1);
      check("t5v_zero", vga_rdata, 32'h0);

      // Reset with two VGA reads in flight
      next();
      vga_req = 1'b1; vga_addr = 14'd5;
      next(); vga_addr = 14'd7;
      next(); vga_req = 1'b0; rst = 1'b0; settle();
      check("t6_rst_gnt", vga_gnt, 0);
      check("t6_rst_rdata", vga_rdata, 32'h0);
      next(); rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("t6_no_vga_rv_%0d", k), vga_rvalid, 0);
         check($sformatf("t6_no_cpu_rv_%0d", k), cpu_rvalid, 0);
         next();
      end
      vga_req = 1'b1; vga_addr = 14'd5; settle();
      check("t6_new_gnt", vga_gnt, 1);
      next(); vga_req = 1'b0;
      next(); next(); settle();
      check("t6_new_rvalid", vga_rvalid, 1);
      check("t6_new_rdata", vga_rdata, 32'hDEADBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
